// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   - reset fetch address default and NOP encoding
//   - fetch_entry_t: one buffered instruction together with its PC
//   - inst_op / inst_funct: op and funct field extraction, shared with the
//     main decoder so both agree on the bit positions
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [5:0] inst_op(input logic [31:0] inst);
    return inst[31:26];
  endfunction

  function automatic logic [5:0] inst_funct(input logic [31:0] inst);
    return inst[5:0];
  endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// Instruction buffer: DEPTH entries of {pc, inst}.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   flush       - synchronous flush (empties the buffer)
//   push, data  - write one entry; accepted when not full, or full with pop
//   pop         - remove head entry (ignored when empty)
//   head        - head entry, all-zero when empty (registered storage only)
//   count       - number of valid entries
//   empty       - buffer holds no entries
module fetch_unit_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  fetch_entry_t               data,
  input  logic                       pop,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // A push into a full buffer is only legal when the head leaves this cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) mem[wr_ptr] <= data;
  end

  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end.
// Holds the PC, issues word fetches with at most one request in flight,
// buffers responses with their PCs and presents the head to decode.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   imem_req / imem_addr     - fetch request strobe and word address
//   imem_rvalid / imem_rdata - fetch response
//   redirect_valid / _pc     - branch/jump redirect (highest priority)
//   id_ready                 - decode accepts head (low = stall)
//   id_valid/id_inst/id_pc   - head instruction, zero when no instruction
//   id_op / id_funct         - op and funct fields of id_inst
// Handshake: the head transfers to decode in every cycle where
// id_valid && id_ready are both high and no redirect is present.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [5:0]  id_op,
  output logic [5:0]  id_funct
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_CNT = (CW + 1)'(DEPTH);

  logic [31:0]  pc;
  logic [31:0]  req_pc;
  logic         outstanding;
  logic         drop;

  logic         resp;
  logic         push;
  logic         pop;
  logic         issue;
  logic [CW:0]  occ_next;
  logic [CW-1:0] count;
  logic         empty;
  fetch_entry_t head;
  fetch_entry_t push_data;

  assign resp = imem_rvalid && outstanding;
  assign push = resp && !drop && !redirect_valid;
  assign pop  = !empty && id_ready && !redirect_valid;

  // Entries held after this edge; a new request may only go out if its
  // response is guaranteed a free slot.
  assign occ_next = {1'b0, count} - {{CW{1'b0}}, pop} + {{CW{1'b0}}, push};

  assign issue = !rst && !redirect_valid && (!outstanding || imem_rvalid)
                 && (occ_next < DEPTH_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      req_pc      <= '0;
      outstanding <= 1'b0;
      drop        <= 1'b0;
    end else if (redirect_valid) begin
      pc <= redirect_pc & ~32'h3;
      // A response still in flight belongs to the old path: mark it for discard.
      if (outstanding && !imem_rvalid) begin
        drop <= 1'b1;
      end else begin
        outstanding <= 1'b0;
        drop        <= 1'b0;
      end
    end else begin
      if (issue) begin
        pc          <= pc + 32'd4;
        req_pc      <= pc;
        outstanding <= 1'b1;
      end else if (resp) begin
        outstanding <= 1'b0;
      end
      if (resp) drop <= 1'b0;
    end
  end

  assign push_data = '{pc: req_pc, inst: imem_rdata};

  fetch_unit_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .data  (push_data),
    .pop   (pop),
    .head  (head),
    .count (count),
    .empty (empty)
  );

  assign imem_req  = issue;
  assign imem_addr = pc;
  assign id_valid  = !empty;
  assign id_inst   = empty ? NOP_INST : head.inst;
  assign id_pc     = empty ? 32'h0 : head.pc;
  assign id_op     = inst_op(id_inst);
  assign id_funct  = inst_funct(id_inst);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized phase, all
// checked against a transaction-level model of the fetch front end.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam int          DEPTH    = 2;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [5:0]  id_op;
  logic [5:0]  id_funct;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_inst        (id_inst),
    .id_pc          (id_pc),
    .id_op          (id_op),
    .id_funct       (id_funct)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];      // PCs buffered for decode, head first
  logic        mem_busy;      // a request is in flight in the memory model
  int          mem_left;      // cycles until its response
  logic [31:0] mem_addr;
  logic        drop_m;        // in-flight response belongs to a stale path
  logic [31:0] next_fetch;    // address the next request must carry
  int          lat;           // latency for newly issued requests

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_3C3C;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    mem_busy   = 1'b0;
    mem_left   = 0;
    mem_addr   = 32'h0;
    drop_m     = 1'b0;
    next_fetch = RESET_PC;
  endtask

  // One clock cycle: drive inputs mid-cycle, check outputs, advance model.
  task automatic cycle(input logic r, input logic rdy, input logic redir,
                       input logic [31:0] tgt, input logic stray);
    logic        resp_m;
    logic        pop_m;
    logic        push_m;
    logic        exp_req;
    logic [31:0] hd;
    int          occ;
    @(negedge clk);
    if (mem_busy && mem_left > 0) mem_left--;
    resp_m         = mem_busy && (mem_left == 0);
    rst            = r;
    id_ready       = rdy;
    redirect_valid = redir;
    redirect_pc    = tgt;
    imem_rvalid    = resp_m || stray;
    imem_rdata     = resp_m ? mem_word(mem_addr) : 32'hDEAD_BEEF;
    #1;
    pop_m   = (exp_q.size() > 0) && rdy && !redir;
    push_m  = resp_m && !drop_m && !redir;
    occ     = exp_q.size() - (pop_m ? 1 : 0) + (push_m ? 1 : 0);
    exp_req = !r && !redir && (!mem_busy || resp_m) && (occ < DEPTH);

    check_val("id_valid", 32'(id_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      hd = exp_q[0];
      check_val("id_pc",    id_pc,    hd);
      check_val("id_inst",  id_inst,  mem_word(hd));
      check_val("id_op",    32'(id_op),    32'(mem_word(hd) >> 26));
      check_val("id_funct", 32'(id_funct), 32'(mem_word(hd) & 32'h3F));
    end else begin
      check_val("id_pc_empty",    id_pc,          32'h0);
      check_val("id_inst_empty",  id_inst,        32'h0);
      check_val("id_op_empty",    32'(id_op),     32'h0);
      check_val("id_funct_empty", 32'(id_funct),  32'h0);
    end
    check_val("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) check_val("imem_addr", imem_addr, next_fetch);

    if (r) begin
      model_clear();
    end else if (redir) begin
      exp_q.delete();
      if (mem_busy && !resp_m) begin
        drop_m = 1'b1;
      end else begin
        mem_busy = 1'b0;
        drop_m   = 1'b0;
      end
      next_fetch = tgt & ~32'h3;
    end else begin
      if (pop_m) void'(exp_q.pop_front());
      if (resp_m) begin
        if (!drop_m) exp_q.push_back(mem_addr);
        drop_m   = 1'b0;
        mem_busy = 1'b0;
      end
      if (exp_req) begin
        mem_busy   = 1'b1;
        mem_addr   = next_fetch;
        mem_left   = lat;
        next_fetch = next_fetch + 32'd4;
      end
    end
  endtask

  task automatic run(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, rdy, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic found;
    rst            = 1'b1;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    id_ready       = 1'b1;
    lat            = 1;
    model_clear();

    // Streaming with single-cycle memory.
    do_reset();
    run(8, 1'b1);

    // Decode stall then release.
    run(6, 1'b0);
    run(8, 1'b1);

    // Redirect while a slow request to BFC00008 is in flight.
    lat = 3;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mem_busy && mem_addr == 32'hBFC0_0008 && mem_left >= 2) found = 1'b1;
      else cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    end
    check_val("reach_inflight_08", 32'(found), 32'h1);
    cycle(1'b0, 1'b1, 1'b1, 32'hBFC0_0100, 1'b0);
    run(14, 1'b1);

    // Redirect coinciding with a response and a pop.
    lat = 1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mem_busy && mem_left == 1 && exp_q.size() > 0) found = 1'b1;
      else cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    end
    check_val("reach_resp_pop", 32'(found), 32'h1);
    cycle(1'b0, 1'b1, 1'b1, 32'hBFC0_0200, 1'b0);
    run(6, 1'b1);

    // Address wrap, aligned and unaligned targets.
    cycle(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    run(6, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
    run(6, 1'b1);

    // Reset with a request in flight and data buffered, then a stray response.
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (mem_busy && exp_q.size() > 0) found = 1'b1;
      else cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    end
    check_val("reach_busy_buffered", 32'(found), 32'h1);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    run(8, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      lat = $urandom_range(1, 3);
      cycle(($urandom_range(0, 499) == 0),
            ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 19) == 0),
            $urandom, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
